// File: rtl/onchip_sram_dp_param.sv
// Parametrised true-dual-port on-chip SRAM with two Avalon-MM slave ports,
// mixed-port write forwarding, s1-priority write collisions and a clear engine.

// Per-port read-return pipeline: READ_LATENCY stages, frozen while clken is low.
module onchip_sram_dp_param_rdpipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clken,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clken) begin
      vld_d[0] = load;
      if (load) dat_d[0] = load_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        // Data only moves with a valid token so the output holds between pulses.
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign rdata  = dat_q[READ_LATENCY-1];
  assign rvalid = vld_q[READ_LATENCY-1] & clken;

endmodule

module onchip_sram_dp_param #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 11,
  parameter int    DEPTH        = 2048,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic                    chipselect,
  input  logic                    chipselect2,
  input  logic                    read,
  input  logic                    read2,
  input  logic                    write,
  input  logic                    write2,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  input  logic                    clken,
  input  logic                    clken2,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid,
  output logic                    readdatavalid2,
  output logic                    waitrequest,
  output logic                    waitrequest2
);

  localparam int             NB       = DATA_WIDTH / 8;
  localparam int             IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_rng1, in_rng2;
  logic                  acc1, acc2, we1, we2, re1, re2;
  logic                  hit_2on1, hit_1on2;
  logic [IDX_W-1:0]      idx1, idx2;
  logic [DATA_WIDTH-1:0] mem_rd1, mem_rd2, rd_val1, rd_val2;

  // Preloading from INIT_FILE is handled by the vendor memory-init flow.
  logic unused_init_file;
  assign unused_init_file = (INIT_FILE != "");

  // ---------------- clear engine ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q == ST_CLEAR);
  assign clr_busy     = busy;
  assign waitrequest  = busy;
  assign waitrequest2 = busy;

  // ---------------- address decode / accept ----------------
  if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial_map
    assign in_rng1 = (address  < ADDR_WIDTH'(DEPTH));
    assign in_rng2 = (address2 < ADDR_WIDTH'(DEPTH));
  end else begin : g_full_map
    assign in_rng1 = 1'b1;
    assign in_rng2 = 1'b1;
  end

  assign idx1 = address[IDX_W-1:0];
  assign idx2 = address2[IDX_W-1:0];

  assign acc1 = chipselect  & (read  | write)  & clken  & ~busy;
  assign acc2 = chipselect2 & (read2 | write2) & clken2 & ~busy;
  assign we1  = acc1 & write  & in_rng1;
  assign we2  = acc2 & write2 & in_rng2;
  // A combined read+write strobe is a write only.
  assign re1  = acc1 & read  & ~write;
  assign re2  = acc2 & read2 & ~write2;

  assign hit_2on1 = we2 && (address2 == address);
  assign hit_1on2 = we1 && (address  == address2);

  // ---------------- read value with cross-port forwarding ----------------
  assign mem_rd1 = mem[idx1];
  assign mem_rd2 = mem[idx2];

  always_comb begin
    rd_val1 = '0;
    rd_val2 = '0;
    for (int b = 0; b < NB; b++) begin
      rd_val1[b*8 +: 8] = (hit_2on1 && byteenable2[b]) ? writedata2[b*8 +: 8]
                                                        : mem_rd1[b*8 +: 8];
      rd_val2[b*8 +: 8] = (hit_1on2 && byteenable[b])  ? writedata[b*8 +: 8]
                                                        : mem_rd2[b*8 +: 8];
    end
    if (!in_rng1) rd_val1 = '0;
    if (!in_rng2) rd_val2 = '0;
  end

  // ---------------- array write ----------------
  // NOTE: the array is deliberately left out of reset: resetting it would turn
  // the RAM into flops, and reset must not disturb the stored contents.
  always_ff @(posedge clk) begin
    if (busy) mem[cnt_q] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (we2 && byteenable2[b]) mem[idx2][b*8 +: 8] <= writedata2[b*8 +: 8];
    end
    // s1 is scheduled last so it wins lanes both ports write.
    for (int b = 0; b < NB; b++) begin
      if (we1 && byteenable[b]) mem[idx1][b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  // ---------------- read-return pipelines ----------------
  onchip_sram_dp_param_rdpipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe1 (
    .clk       (clk),
    .rst_n     (reset_n),
    .clken     (clken),
    .load      (re1),
    .load_data (rd_val1),
    .rdata     (readdata),
    .rvalid    (readdatavalid)
  );

  onchip_sram_dp_param_rdpipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe2 (
    .clk       (clk),
    .rst_n     (reset_n),
    .clken     (clken2),
    .load      (re2),
    .load_data (rd_val2),
    .rdata     (readdata2),
    .rvalid    (readdatavalid2)
  );

endmodule

// File: tb/tb_onchip_sram_dp_param.sv
// Directed self-checking bench for onchip_sram_dp_param: byte lanes, forwarding,
// collisions, clken stall, out-of-range access, clear engine and reset mid-clear.
module tb_onchip_sram_dp_param;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 2048;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr_req;
  logic          clr_busy;
  logic [AW-1:0] address, address2;
  logic [3:0]    byteenable, byteenable2;
  logic          chipselect, chipselect2;
  logic          read, read2, write, write2;
  logic [DW-1:0] writedata, writedata2;
  logic          clken, clken2;
  logic [DW-1:0] readdata, readdata2;
  logic          readdatavalid, readdatavalid2;
  logic          waitrequest, waitrequest2;

  int n_checks = 0;
  int n_fail   = 0;

  onchip_sram_dp_param #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL),
    .INIT_FILE    ("")
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr_req        (clr_req),
    .clr_busy       (clr_busy),
    .address        (address),
    .address2       (address2),
    .byteenable     (byteenable),
    .byteenable2    (byteenable2),
    .chipselect     (chipselect),
    .chipselect2    (chipselect2),
    .read           (read),
    .read2          (read2),
    .write          (write),
    .write2         (write2),
    .writedata      (writedata),
    .writedata2     (writedata2),
    .clken          (clken),
    .clken2         (clken2),
    .readdata       (readdata),
    .readdata2      (readdata2),
    .readdatavalid  (readdatavalid),
    .readdatavalid2 (readdatavalid2),
    .waitrequest    (waitrequest),
    .waitrequest2   (waitrequest2)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end of test, required end within 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect  = 1'b0; read  = 1'b0; write  = 1'b0;
    chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    tick();
    idle();
  endtask

  // Called right after the accepting edge; checks the single pulse position.
  task automatic expect_read(input int port, input logic [DW-1:0] exp, input string tag);
    for (int j = 0; j <= RL; j++) begin
      if (j > 0) tick();
      check({tag, "_rdv"}, (port == 1) ? readdatavalid : readdatavalid2, (j == RL - 1));
      if (j == RL - 1) check({tag, "_data"}, (port == 1) ? readdata : readdata2, exp);
    end
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                    input string tag);
    if (port == 1) begin chipselect  = 1'b1; read  = 1'b1; address  = a; end
    else           begin chipselect2 = 1'b1; read2 = 1'b1; address2 = a; end
    tick();
    idle();
    expect_read(port, exp, tag);
  endtask

  // Counts cycles with clr_busy high from the current sample on, bounded.
  task automatic measure_clear(output int cyc, output int wr_bad, output int rdv_n,
                               output logic [DW-1:0] last);
    cyc = 0; wr_bad = 0; rdv_n = 0; last = '0;
    for (int j = 0; j < DEPTH + 16; j++) begin
      if (!clr_busy) break;
      cyc++;
      if (waitrequest !== 1'b1 || waitrequest2 !== 1'b1) wr_bad++;
      if (readdatavalid2) begin rdv_n++; last = readdata2; end
      tick();
    end
  endtask

  int            cyc, wr_bad, rdv_n;
  logic [DW-1:0] last;

  initial begin
    reset_n = 1'b0; clr_req = 1'b0;
    address = '0; address2 = '0; byteenable = 4'hF; byteenable2 = 4'hF;
    writedata = '0; writedata2 = '0; clken = 1'b1; clken2 = 1'b1;
    idle();
    #12;
    check("rst_readdata",  readdata,       0);
    check("rst_readdata2", readdata2,      0);
    check("rst_rdv",       readdatavalid,  0);
    check("rst_rdv2",      readdatavalid2, 0);
    check("rst_busy",      clr_busy,       0);
    check("rst_wr",        waitrequest,    0);
    check("rst_wr2",       waitrequest2,   0);
    reset_n = 1'b1;
    tick();

    // Byte-enable write, read back on s2 and on s1.
    wr1(5, 32'h11223344, 4'hF);
    wr1(5, 32'hAABBCCDD, 4'b0101);
    rd(2, 5, 32'h11BB33DD, "be_rd2");
    rd(1, 5, 32'h11BB33DD, "be_rd1");

    // Mixed-port forwarding, full and partial lanes, both directions.
    chipselect = 1'b1; write = 1'b1; address = 7; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    chipselect2 = 1'b1; read2 = 1'b1; address2 = 7;
    tick(); idle();
    expect_read(2, 32'hDEADBEEF, "fwd_full");
    wr1(8, 32'h01020304, 4'hF);
    chipselect = 1'b1; write = 1'b1; address = 8; writedata = 32'hAABBCCDD; byteenable = 4'b1100;
    chipselect2 = 1'b1; read2 = 1'b1; address2 = 8;
    tick(); idle();
    expect_read(2, 32'hAABB0304, "fwd_part");
    chipselect2 = 1'b1; write2 = 1'b1; address2 = 8; writedata2 = 32'h55667788; byteenable2 = 4'b0011;
    chipselect = 1'b1; read = 1'b1; address = 8;
    tick(); idle();
    expect_read(1, 32'hAABB7788, "fwd_rev");

    // Write-write collision: s1 owns lanes 1:0, s2 alone supplies lanes 3:2.
    chipselect = 1'b1; write = 1'b1; address = 9; writedata = 32'h000000FF; byteenable = 4'b0011;
    chipselect2 = 1'b1; write2 = 1'b1; address2 = 9; writedata2 = 32'hFFFF0000; byteenable2 = 4'hF;
    tick(); idle();
    byteenable2 = 4'hF;
    rd(1, 9, 32'hFFFF00FF, "ww_coll");

    // read+write together on one port is a write with no read return.
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 10;
    writedata = 32'h00000055; byteenable = 4'hF;
    tick(); idle();
    for (int j = 0; j <= RL; j++) begin
      if (j > 0) tick();
      check("rw_no_rdv", readdatavalid, 0);
    end
    rd(2, 10, 32'h00000055, "rw_data");

    // clken stall holds the pending read and masks readdatavalid.
    wr1(3, 32'h12345678, 4'hF);
    chipselect = 1'b1; read = 1'b1; address = 3;
    tick(); idle();
    clken = 1'b0;
    check("stall_rdv0", readdatavalid, 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("stall_rdv", readdatavalid, 0);
    end
    clken = 1'b1;
    check("stall_resume0", readdatavalid, 0);
    tick();
    check("stall_resume_rdv",  readdatavalid, 1);
    check("stall_resume_data", readdata,      32'h12345678);
    tick();
    check("stall_pulse_end", readdatavalid, 0);

    // Out-of-range: write dropped (would alias addr 0), read returns zero.
    wr1(0, 32'h0BADBEEF, 4'hF);
    wr1(12'd2048, 32'hCAFEF00D, 4'hF);
    rd(2, 12'd2048, 32'h0, "oor_rd");
    rd(2, 0, 32'h0BADBEEF, "oor_alias");

    // Fill the whole array, then clear with a read presented on the sampling edge.
    for (int i = 0; i < DEPTH / 2; i++) begin
      chipselect  = 1'b1; write  = 1'b1; address  = AW'(2 * i);     writedata  = '1;
      chipselect2 = 1'b1; write2 = 1'b1; address2 = AW'(2 * i + 1); writedata2 = '1;
      byteenable = 4'hF; byteenable2 = 4'hF;
      tick();
    end
    idle();
    clr_req = 1'b1; chipselect2 = 1'b1; read2 = 1'b1; address2 = 0;
    tick();
    clr_req = 1'b0; address2 = 1;
    measure_clear(cyc, wr_bad, rdv_n, last);
    idle();
    check("clr_cycles",    cyc,    DEPTH);
    check("clr_waitreq",   wr_bad, 0);
    check("clr_rdv_count", rdv_n,  1);
    check("clr_preread",   last,   32'hFFFFFFFF);
    rd(2, 0,            32'h0, "clr_addr0");
    rd(1, AW'(DEPTH-1), 32'h0, "clr_addr_last");
    rd(2, 1,            32'h0, "clr_addr1");

    // Reset mid-clear at cnt = 100, then a full clear held long enough to restart.
    wr1(20, 32'h13572468, 4'hF);
    rd(1, 20, 32'h13572468, "pre_rst_rd");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    check("midclr_busy", clr_busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy",      clr_busy,       0);
    check("midrst_wr",        waitrequest,    0);
    check("midrst_wr2",       waitrequest2,   0);
    check("midrst_rdv",       readdatavalid,  0);
    check("midrst_rdv2",      readdatavalid2, 0);
    check("midrst_readdata",  readdata,       0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_idle", clr_busy, 0);
    clr_req = 1'b1;
    tick();
    measure_clear(cyc, wr_bad, rdv_n, last);
    check("reclr_cycles",  cyc,    DEPTH);
    check("reclr_waitreq", wr_bad, 0);
    tick();
    check("restart_busy", clr_busy, 1);
    clr_req = 1'b0;
    measure_clear(cyc, wr_bad, rdv_n, last);
    check("restart_cycles", cyc, DEPTH);
    rd(1, 20, 32'h0, "final_clr_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
